// File: rtl/kalman_pkg.sv
// kalman_pkg: shared types and constants for the multi-channel Kalman tracker.
// Holds the controller state encoding and the guard-bit rule used by every
// saturating add/sub (operands are widened by SAT_EXTRA bits before clamping).
package kalman_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PRED = 2'd1,
    ST_UPD  = 2'd2,
    ST_OUT  = 2'd3
  } kalman_state_e;

  localparam int SAT_EXTRA = 2;

  // Working width of a saturating add/sub on w-bit operands.
  function automatic int sat_width(input int w);
    return w + SAT_EXTRA;
  endfunction

endpackage

// File: rtl/kalman_sat.sv
// kalman_sat: combinational saturating add/sub of two W-bit two's-complement
// operands. The result is formed with guard bits, then clamped to the W-bit range.
module kalman_sat
  import kalman_pkg::*;
#(
  parameter int W = 16
) (
  input  logic signed [W-1:0] a,
  input  logic signed [W-1:0] b,
  input  logic                sub,
  output logic signed [W-1:0] y
);

  localparam int SW = sat_width(W);
  localparam logic signed [SW-1:0] MAX_V = {{(SAT_EXTRA + 1){1'b0}}, {(W - 1){1'b1}}};
  localparam logic signed [SW-1:0] MIN_V = {{(SAT_EXTRA + 1){1'b1}}, {(W - 1){1'b0}}};

  logic signed [SW-1:0] a_x_s;
  logic signed [SW-1:0] b_x_s;
  logic signed [SW-1:0] sum_s;

  // Widen, add or subtract, then clamp to the representable range.
  always_comb begin
    a_x_s = {{SAT_EXTRA{a[W-1]}}, a};
    b_x_s = {{SAT_EXTRA{b[W-1]}}, b};
    if (sub) begin
      sum_s = a_x_s - b_x_s;
    end else begin
      sum_s = a_x_s + b_x_s;
    end
    if (sum_s > MAX_V) begin
      y = MAX_V[W-1:0];
    end else if (sum_s < MIN_V) begin
      y = MIN_V[W-1:0];
    end else begin
      y = sum_s[W-1:0];
    end
  end

endmodule

// File: rtl/kalman_mc.sv
// kalman_mc: NCH-channel angle tracker (predict from gyro rate, correct from
// measured angle) sharing one arithmetic datapath. One transaction runs
// IDLE->PRED->UPD->OUT; clear and bad-channel commands go IDLE->OUT directly.
// Optional feature macro: KALMAN_MC_BIAS_EST_EN enables per-channel gyro bias
// estimation; without it bias reads as zero and out_bias stays zero.
module kalman_mc
  import kalman_pkg::*;
#(
  parameter int W          = 16,
  parameter int NCH        = 3,
  parameter int RATE_SHIFT = 6,
  parameter int K_SHIFT    = 6,
  parameter int B_SHIFT    = 8,
  localparam int CW        = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [CW-1:0]       in_ch,
  input  logic                in_clr,
  input  logic signed [W-1:0] rate,
  input  logic signed [W-1:0] angle_m,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [CW-1:0]       out_ch,
  output logic signed [W-1:0] angle_out,
  output logic signed [W-1:0] out_bias,
  output logic                out_err
);

  kalman_state_e state_r, state_s;

  logic signed [W-1:0] angle_r [NCH];
  logic [CW-1:0]       ch_r;
  logic signed [W-1:0] rate_r;
  logic signed [W-1:0] angm_r;
  logic signed [W-1:0] pred_r;
  logic signed [W-1:0] innov_r;

  logic                accept_s;
  logic                bad_s;
  logic signed [W-1:0] angle_rd_s;
  logic signed [W-1:0] bias_rd_s;
  logic signed [W-1:0] r_eff_s;
  logic signed [W-1:0] rate_step_s;
  logic signed [W-1:0] pred_s;
  logic signed [W-1:0] innov_s;
  logic signed [W-1:0] k_step_s;
  logic signed [W-1:0] angle_new_s;
  logic signed [W-1:0] bias_new_s;

  logic                out_valid_r;
  logic [CW-1:0]       out_ch_r;
  logic signed [W-1:0] angle_out_r;
  logic signed [W-1:0] out_bias_r;
  logic                out_err_r;

  assign accept_s   = in_valid && (state_r == ST_IDLE);
  assign bad_s      = (int'(in_ch) >= NCH);
  assign in_ready   = (state_r == ST_IDLE);
  assign angle_rd_s = angle_r[ch_r];

  // Prediction chain: remove bias from rate, integrate, form innovation.
  kalman_sat #(.W(W)) u_sat_reff  (.a(rate_r),     .b(bias_rd_s),   .sub(1'b1), .y(r_eff_s));
  assign rate_step_s = r_eff_s >>> RATE_SHIFT;
  kalman_sat #(.W(W)) u_sat_pred  (.a(angle_rd_s), .b(rate_step_s), .sub(1'b0), .y(pred_s));
  kalman_sat #(.W(W)) u_sat_innov (.a(angm_r),     .b(pred_s),      .sub(1'b1), .y(innov_s));

  // Correction: apply the fixed gain to the registered innovation.
  assign k_step_s = innov_r >>> K_SHIFT;
  kalman_sat #(.W(W)) u_sat_upd   (.a(pred_r),     .b(k_step_s),    .sub(1'b0), .y(angle_new_s));

`ifdef KALMAN_MC_BIAS_EST_EN
  logic signed [W-1:0] bias_r [NCH];
  logic signed [W-1:0] b_step_s;

  assign bias_rd_s = bias_r[ch_r];
  assign b_step_s  = innov_r >>> B_SHIFT;
  kalman_sat #(.W(W)) u_sat_bias  (.a(bias_rd_s),  .b(b_step_s),    .sub(1'b1), .y(bias_new_s));

  // Per-channel bias storage: cleared by command, nudged against the innovation in UPD.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NCH; i++) begin
        bias_r[i] <= '0;
      end
    end else if (accept_s && in_clr && !bad_s) begin
      bias_r[in_ch] <= '0;
    end else if (state_r == ST_UPD) begin
      bias_r[ch_r] <= bias_new_s;
    end
  end
`else
  assign bias_rd_s  = '0;
  assign bias_new_s = '0;
`endif

  // Controller state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic; clear and bad-channel commands skip the arithmetic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          if (in_clr || bad_s) begin
            state_s = ST_OUT;
          end else begin
            state_s = ST_PRED;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_PRED: state_s = ST_UPD;
      ST_UPD:  state_s = ST_OUT;
      ST_OUT: begin
        if (out_ready) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_OUT;
        end
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // Capture the request at transfer and the prediction results in PRED.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ch_r    <= '0;
      rate_r  <= '0;
      angm_r  <= '0;
      pred_r  <= '0;
      innov_r <= '0;
    end else if (accept_s) begin
      ch_r   <= in_ch;
      rate_r <= rate;
      angm_r <= angle_m;
    end else if (state_r == ST_PRED) begin
      pred_r  <= pred_s;
      innov_r <= innov_s;
    end
  end

  // Per-channel angle storage: cleared by command, written with the corrected angle in UPD.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NCH; i++) begin
        angle_r[i] <= '0;
      end
    end else if (accept_s && in_clr && !bad_s) begin
      angle_r[in_ch] <= '0;
    end else if (state_r == ST_UPD) begin
      angle_r[ch_r] <= angle_new_s;
    end
  end

  // Result registers: loaded on entry to OUT, held until the consumer accepts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_r <= 1'b0;
      out_ch_r    <= '0;
      angle_out_r <= '0;
      out_bias_r  <= '0;
      out_err_r   <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (accept_s && (in_clr || bad_s)) begin
            out_valid_r <= 1'b1;
            out_ch_r    <= in_ch;
            angle_out_r <= '0;
            out_bias_r  <= '0;
            out_err_r   <= bad_s;
          end
        end
        ST_UPD: begin
          out_valid_r <= 1'b1;
          out_ch_r    <= ch_r;
          angle_out_r <= angle_new_s;
          out_bias_r  <= bias_new_s;
          out_err_r   <= 1'b0;
        end
        ST_OUT: begin
          if (out_ready) begin
            out_valid_r <= 1'b0;
          end
        end
        default: begin
          out_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign out_valid = out_valid_r;
  assign out_ch    = out_ch_r;
  assign angle_out = angle_out_r;
  assign out_bias  = out_bias_r;
  assign out_err   = out_err_r;

endmodule

// File: tb/tb_kalman_mc.sv
// tb_kalman_mc: directed self-checking bench for kalman_mc (W=16, NCH=3,
// shifts 6/6/8). Expected values are hand-computed fixed-point results.
// Build with KALMAN_MC_BIAS_EST_EN defined to exercise the bias estimator.
module tb_kalman_mc;

  localparam int W  = 16;
  localparam int CW = 2;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                in_valid = 1'b0;
  logic                in_ready;
  logic [CW-1:0]       in_ch = '0;
  logic                in_clr = 1'b0;
  logic signed [W-1:0] rate = '0;
  logic signed [W-1:0] angle_m = '0;
  logic                out_valid;
  logic                out_ready = 1'b1;
  logic [CW-1:0]       out_ch;
  logic signed [W-1:0] angle_out;
  logic signed [W-1:0] out_bias;
  logic                out_err;

  int n_checks = 0;
  int n_errors = 0;

  kalman_mc #(.W(W), .NCH(3), .RATE_SHIFT(6), .K_SHIFT(6), .B_SHIFT(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_ch(in_ch), .in_clr(in_clr),
    .rate(rate), .angle_m(angle_m),
    .out_valid(out_valid), .out_ready(out_ready), .out_ch(out_ch),
    .angle_out(angle_out), .out_bias(out_bias), .out_err(out_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Offer one request, then count edges (the accepting edge is edge 1) until out_valid.
  task automatic send(input string tag, input int ch, input bit clr,
                      input int r, input int am, input int exp_lat);
    int n;
    int lat;
    @(negedge clk);
    in_ch = CW'(ch); in_clr = clr; rate = W'(r); angle_m = W'(am); in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_ready"}, int'(in_ready), 1);
    @(posedge clk); #1;
    // Scramble inputs after the transfer: the transaction must use captured values.
    in_valid = 1'b0; in_ch = 2'd1; in_clr = 1'b0; rate = 16'sh1234; angle_m = -16'sd4000;
    lat = 1;
    while (!out_valid && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, "_lat"}, lat, exp_lat);
  endtask

  // Check result fields, then complete the handshake (out_ready high).
  task automatic expect_out(input string tag, input int ch, input int ang,
                            input int bias, input int err);
    check({tag, "_ch"},    int'(out_ch), ch);
    check({tag, "_angle"}, angle_out, ang);
    check({tag, "_bias"},  out_bias, bias);
    check({tag, "_err"},   int'(out_err), err);
    @(posedge clk); #1;
    check({tag, "_vdone"}, int'(out_valid), 0);
    check({tag, "_rdone"}, int'(in_ready), 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid"}, int'(out_valid), 0);
    check({tag, "_ch"},    int'(out_ch), 0);
    check({tag, "_angle"}, angle_out, 0);
    check({tag, "_bias"},  out_bias, 0);
    check({tag, "_err"},   int'(out_err), 0);
    check({tag, "_ready"}, int'(in_ready), 1);
  endtask

  initial begin
    #23;
    check_reset_outputs("rst");
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst_rel_ready", int'(in_ready), 1);

`ifdef KALMAN_MC_BIAS_EST_EN
    // innov=2560: angle 0+40, bias 0-(2560>>>8)=-10.
    send("b_ch2", 2, 1'b0, 0, 2560, 3);
    expect_out("b_ch2", 2, 40, -10, 0);
    // r_eff=0-(-10)=10, 10>>>6=0, pred=40, innov=0: unchanged.
    send("b_ch2b", 2, 1'b0, 0, 40, 3);
    expect_out("b_ch2b", 2, 40, -10, 0);
    // pred=10, innov=-10: angle 9, bias 0-(-1)=1.
    send("b_ch0", 0, 1'b0, 640, 0, 3);
    expect_out("b_ch0", 0, 9, 1, 0);
`else
    // pred=10, innov=-10, -10>>>6=-1 -> 9.
    send("ch0", 0, 1'b0, 640, 0, 3);
    expect_out("ch0", 0, 9, 0, 0);
    // pred=511, innov saturates to -32768, >>>6=-512 -> -1.
    send("sat", 1, 1'b0, 32767, -32768, 3);
    expect_out("sat", 1, -1, 0, 0);

    // Back-pressure: pred=10, innov=990, 990>>>6=15 -> 25; hold 5 cycles.
    out_ready = 1'b0;
    send("stall", 2, 1'b0, 640, 1000, 3);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("stall_valid", int'(out_valid), 1);
      check("stall_angle", angle_out, 25);
      check("stall_ch", int'(out_ch), 2);
      check("stall_ready", int'(in_ready), 0);
    end
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk); #1;
    check("stall_vdone", int'(out_valid), 0);
    check("stall_rdone", int'(in_ready), 1);

    // Clear ch2: straight to OUT on the accepting edge.
    send("clr", 2, 1'b1, 640, 1000, 1);
    expect_out("clr", 2, 0, 0, 0);
    // ch0 retained 9: pred=9, innov=64, 64>>>6=1 -> 10.
    send("ch0b", 0, 1'b0, 0, 73, 3);
    expect_out("ch0b", 0, 10, 0, 0);
    // Bad channel: error, zeros, no state change.
    send("bad", 3, 1'b0, 640, 1000, 1);
    expect_out("bad", 3, 0, 0, 1);
    // ch1 retained -1: pred=-1, innov=0 -> -1.
    send("ch1b", 1, 1'b0, 0, -1, 3);
    expect_out("ch1b", 1, -1, 0, 0);
    // ch2 cleared to 0: pred=0, innov=0 -> 0 (25 would give 24).
    send("ch2c", 2, 1'b0, 0, 0, 3);
    expect_out("ch2c", 2, 0, 0, 0);

    // Reset while in UPD discards the transaction.
    @(negedge clk);
    in_ch = 2'd0; in_clr = 1'b0; rate = 16'sd640; angle_m = 16'sd0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("mid_rst");
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    check("mid_rel_ready", int'(in_ready), 1);
    check("mid_rel_valid", int'(out_valid), 0);
    // ch0 back to 0, so the first vector repeats its result.
    send("ch0r", 0, 1'b0, 640, 0, 3);
    expect_out("ch0r", 0, 9, 0, 0);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
